// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter: aligns and extends load data,
// selects the write-back source and drives the register-file write port one cycle later.
module mem_wb_stage #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_reg_write,
    input  logic [AW-1:0] in_rd,
    input  logic [1:0]    in_wb_sel,
    input  logic [2:0]    in_funct3,
    input  logic [DW-1:0] in_alu_result,
    input  logic [DW-1:0] in_mem_rdata,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_imm,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          out_valid,
    output logic [31:0]   retire_cnt
);

    logic          vld_p1;
    logic          reg_write_p1;
    logic [AW-1:0] rd_p1;
    logic [DW-1:0] wd_p1;
    logic [31:0]   retire_p1;
    logic [DW-1:0] wd_p0;

    // Byte/half lane selection plus sign or zero extension; unknown codes pass the full word.
    function automatic logic [DW-1:0] format_load(
        input logic [2:0]    funct3,
        input logic [1:0]    off,
        input logic [DW-1:0] rdata
    );
        logic signed [7:0]  byte_lane;
        logic signed [15:0] half_lane;
        logic [DW-1:0]      result;
        case (off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  result = {{(DW-8){byte_lane[7]}}, byte_lane};
            3'b001:  result = {{(DW-16){half_lane[15]}}, half_lane};
            3'b100:  result = {{(DW-8){1'b0}}, byte_lane};
            3'b101:  result = {{(DW-16){1'b0}}, half_lane};
            default: result = rdata;
        endcase
        return result;
    endfunction

    // Stage p0: write-back source selection ahead of the register
    always_comb begin
        wd_p0 = in_alu_result;
        case (in_wb_sel)
            2'd0:    wd_p0 = in_alu_result;
            2'd1:    wd_p0 = format_load(in_funct3, in_alu_result[1:0], in_mem_rdata);
            2'd2:    wd_p0 = in_pc + DW'(4);
            default: wd_p0 = in_imm;
        endcase
    end

    // Stage p1: WB entry; an entry retires on the edge where it leaves (flush or no stall)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            rd_p1        <= '0;
            wd_p1        <= '0;
            retire_p1    <= '0;
        end else begin
            if (vld_p1 && (flush || !stall)) begin
                retire_p1 <= retire_p1 + 32'd1;
            end
            if (flush) begin
                vld_p1       <= 1'b0;
                reg_write_p1 <= 1'b0;
                rd_p1        <= '0;
                wd_p1        <= '0;
            end else if (!stall) begin
                vld_p1       <= in_valid;
                reg_write_p1 <= in_reg_write;
                rd_p1        <= in_rd;
                wd_p1        <= wd_p0;
            end
        end
    end

    assign we         = vld_p1 & reg_write_p1 & (rd_p1 != '0);
    assign wa         = rd_p1;
    assign wd         = wd_p1;
    assign out_valid  = vld_p1;
    assign retire_cnt = retire_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: the driver queues hand-computed post-edge results,
// a monitor pops one per clock and compares.
module tb_mem_wb_stage;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        out_valid;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ov;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] rc;
        bit          chk_data;
        string       name;
    } exp_t;

    exp_t sb[$];

    mem_wb_stage #(.AW(5), .DW(32)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc(in_pc), .in_imm(in_imm),
        .we(we), .wa(wa), .wd(wd), .out_valid(out_valid), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one queued expectation per clock edge, sampled 1 time unit after it.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32({e.name, ".out_valid"}, 32'(out_valid), 32'(e.ov));
            check32({e.name, ".we"}, 32'(we), 32'(e.we));
            check32({e.name, ".retire_cnt"}, retire_cnt, e.rc);
            if (e.chk_data) begin
                check32({e.name, ".wa"}, 32'(wa), 32'(e.wa));
                check32({e.name, ".wd"}, wd, e.wd);
            end
        end
    end

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [31:0] imm);
        in_valid      = v;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_pc         = pc;
        in_imm        = imm;
    endtask

    task automatic tick(input string name, input logic ov, input logic e_we, input logic [4:0] e_wa,
                        input logic [31:0] e_wd, input logic [31:0] e_rc, input bit chk_data);
        exp_t e;
        e.name = name; e.ov = ov; e.we = e_we; e.wa = e_wa; e.wd = e_wd; e.rc = e_rc;
        e.chk_data = chk_data;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 5'd3, 2'd0, 3'b000, 32'h0000AAAA, RD, 32'h0, 32'h0);
        tick("reset", 0, 0, 5'd0, 32'h0, 32'd0, 1);

        rstn = 1'b1;
        drive(1, 1, 5'd5, 2'd0, 3'b000, 32'h00001234, RD, 32'h0, 32'h0);
        tick("alu", 1, 1, 5'd5, 32'h00001234, 32'd0, 1);
        drive(1, 1, 5'd6, 2'd1, 3'b000, 32'h00000103, RD, 32'h0, 32'h0);
        tick("lb_off3", 1, 1, 5'd6, 32'hFFFFFF80, 32'd1, 1);
        drive(1, 1, 5'd7, 2'd1, 3'b100, 32'h00000103, RD, 32'h0, 32'h0);
        tick("lbu_off3", 1, 1, 5'd7, 32'h00000080, 32'd2, 1);
        drive(1, 1, 5'd8, 2'd1, 3'b000, 32'h00000101, RD, 32'h0, 32'h0);
        tick("lb_off1", 1, 1, 5'd8, 32'h0000007F, 32'd3, 1);
        drive(1, 1, 5'd9, 2'd1, 3'b001, 32'h00000102, RD, 32'h0, 32'h0);
        tick("lh_off2", 1, 1, 5'd9, 32'hFFFF80FF, 32'd4, 1);
        drive(1, 1, 5'd10, 2'd1, 3'b101, 32'h00000103, RD, 32'h0, 32'h0);
        tick("lhu_off3", 1, 1, 5'd10, 32'h000080FF, 32'd5, 1);
        drive(1, 1, 5'd11, 2'd1, 3'b010, 32'h00000102, RD, 32'h0, 32'h0);
        tick("lw_off2", 1, 1, 5'd11, 32'h80FF7F01, 32'd6, 1);
        drive(1, 1, 5'd12, 2'd1, 3'b011, 32'h00000101, RD, 32'h0, 32'h0);
        tick("undef_f3", 1, 1, 5'd12, 32'h80FF7F01, 32'd7, 1);
        drive(1, 1, 5'd0, 2'd0, 3'b000, 32'h00000055, RD, 32'h0, 32'h0);
        tick("x0", 1, 0, 5'd0, 32'h00000055, 32'd8, 1);
        drive(1, 1, 5'd1, 2'd2, 3'b000, 32'h00000011, RD, 32'hFFFFFFFC, 32'h0);
        tick("jal_wrap", 1, 1, 5'd1, 32'h00000000, 32'd9, 1);
        drive(1, 1, 5'd2, 2'd3, 3'b000, 32'h00000022, RD, 32'h0, 32'hDEAD0000);
        tick("lui", 1, 1, 5'd2, 32'hDEAD0000, 32'd10, 1);
        drive(1, 0, 5'd4, 2'd0, 3'b000, 32'h00000099, RD, 32'h0, 32'h0);
        tick("no_rw", 1, 0, 5'd4, 32'h00000099, 32'd11, 1);
        drive(1, 1, 5'd7, 2'd0, 3'b000, 32'h00000777, RD, 32'h0, 32'h0);
        tick("pre_stall", 1, 1, 5'd7, 32'h00000777, 32'd12, 1);

        stall = 1'b1;
        drive(1, 1, 5'd13, 2'd0, 3'b000, 32'h00000BAD, RD, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick("stall_hold", 1, 1, 5'd7, 32'h00000777, 32'd12, 1);
        flush = 1'b1;
        tick("flush_stall", 0, 0, 5'd0, 32'h0, 32'd13, 1);
        flush = 1'b0; stall = 1'b0;
        drive(0, 1, 5'd14, 2'd0, 3'b000, 32'h00000001, RD, 32'h0, 32'h0);
        tick("invalid_in", 0, 0, 5'd0, 32'h0, 32'd13, 0);

        rstn = 1'b0;
        drive(1, 1, 5'd15, 2'd0, 3'b000, 32'h00000015, RD, 32'h0, 32'h0);
        tick("reset2", 0, 0, 5'd0, 32'h0, 32'd0, 1);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'(16 + i), 2'd0, 3'b000, 32'h100 + 32'(i), RD, 32'h0, 32'h0);
            tick("b2b", 1, 1, 5'(16 + i), 32'h100 + 32'(i), 32'(i), 1);
        end
        drive(0, 0, 5'd0, 2'd0, 3'b000, 32'h0, RD, 32'h0, 32'h0);
        tick("b2b_drain", 0, 0, 5'd0, 32'h0, 32'd4, 0);

        drive(1, 1, 5'd20, 2'd0, 3'b000, 32'h00000200, RD, 32'h0, 32'h0);
        tick("stream0", 1, 1, 5'd20, 32'h00000200, 32'd4, 1);
        drive(1, 1, 5'd21, 2'd0, 3'b000, 32'h00000201, RD, 32'h0, 32'h0);
        tick("stream1", 1, 1, 5'd21, 32'h00000201, 32'd5, 1);
        rstn = 1'b0;
        drive(1, 1, 5'd22, 2'd0, 3'b000, 32'h00000202, RD, 32'h0, 32'h0);
        #2;
        check32("pre_edge_reset.we", 32'(we), 32'd1);
        check32("pre_edge_reset.wa", 32'(wa), 32'd21);
        check32("pre_edge_reset.wd", wd, 32'h00000201);
        check32("pre_edge_reset.retire_cnt", retire_cnt, 32'd5);
        tick("reset_mid", 0, 0, 5'd0, 32'h0, 32'd0, 1);
        rstn = 1'b1;
        drive(1, 1, 5'd22, 2'd0, 3'b000, 32'h00000300, RD, 32'h0, 32'h0);
        tick("after_reset", 1, 1, 5'd22, 32'h00000300, 32'd0, 1);
        flush = 1'b1;
        tick("flush_only", 0, 0, 5'd0, 32'h0, 32'd1, 1);
        flush = 1'b0;
        drive(0, 0, 5'd0, 2'd0, 3'b000, 32'h0, RD, 32'h0, 32'h0);
        tick("idle", 0, 0, 5'd0, 32'h0, 32'd1, 0);

        @(posedge clk);
        #3;
        check32("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end within 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
